// File: rtl/duc_interp_ctrl_if.sv
// DUC interpolation control: request and ctrlport write bundle.
// slave = controller side, master = requester / bus side.
interface duc_interp_ctrl_if;
  logic [15:0] cfg_rate;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        m_ctrlport_req_wr;
  logic [19:0] m_ctrlport_req_addr;
  logic [31:0] m_ctrlport_req_data;
  logic        m_ctrlport_resp_ack;

  modport slave (
    input  cfg_rate,
    input  cfg_valid,
    output cfg_ready,
    output m_ctrlport_req_wr,
    output m_ctrlport_req_addr,
    output m_ctrlport_req_data,
    input  m_ctrlport_resp_ack
  );

  modport master (
    output cfg_rate,
    output cfg_valid,
    input  cfg_ready,
    input  m_ctrlport_req_wr,
    input  m_ctrlport_req_addr,
    input  m_ctrlport_req_data,
    output m_ctrlport_resp_ack
  );
endinterface

// File: rtl/duc_interp_ctrl.sv
// DUC interpolation controller: splits a rate into halfband
// stages and a CIC rate, then programs both over ctrlport.
module duc_interp_ctrl #(
  parameter int          NUM_HB         = 3,
  parameter int          CIC_MAX_INTERP = 128,
  parameter logic [19:0] SR_M_ADDR      = 20'h0,
  parameter logic [19:0] SR_INTERP_ADDR = 20'h8,
  parameter int          TIMEOUT        = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  duc_interp_ctrl_if.slave bus,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [7:0] hb_enables,
  output logic [7:0] cic_rate
);

  typedef enum logic [2:0] {
    S_IDLE, S_FACTOR, S_CHECK, S_WR_M,
    S_WAIT_M, S_WR_I, S_WAIT_I, S_FINISH
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_rate;
  logic [15:0] r_rem;
  logic [7:0]  r_hb;
  logic [15:0] r_wcnt;
  logic [1:0]  r_err;
  logic [19:0] r_addr;
  logic [31:0] r_data;
  logic [7:0]  r_hb_en;
  logic [7:0]  r_cic;
  logic        w_ready;
  logic        w_wr;
  logic        w_done;
  logic        w_error;
  logic        w_halve;
  logic        w_tmo;
  logic        w_ack;
  logic        w_rem_zero;
  logic        w_rem_big;

  assign w_ack      = bus.m_ctrlport_resp_ack;
  assign w_rem_zero = (r_rem == 16'd0);
  assign w_rem_big  = (r_rem > 16'(CIC_MAX_INTERP));
  assign w_halve    = !r_rem[0] && !w_rem_zero
                   && (r_hb < 8'(NUM_HB));
  assign w_tmo      = (r_wcnt == 16'(TIMEOUT - 1));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next state and strobes
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_wr    = 1'b0;
    w_done  = 1'b0;
    w_error = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.cfg_valid) w_next = S_FACTOR;
      end
      S_FACTOR: if (!w_halve) w_next = S_CHECK;
      S_CHECK: begin
        if (w_rem_zero || w_rem_big) w_next = S_FINISH;
        else                         w_next = S_WR_M;
      end
      S_WR_M: begin
        w_wr   = 1'b1;
        w_next = S_WAIT_M;
      end
      S_WAIT_M: begin
        if (w_ack)      w_next = S_WR_I;
        else if (w_tmo) w_next = S_FINISH;
      end
      S_WR_I: begin
        w_wr   = 1'b1;
        w_next = S_WAIT_I;
      end
      S_WAIT_I: if (w_ack || w_tmo) w_next = S_FINISH;
      S_FINISH: begin
        w_done  = (r_err == 2'd0);
        w_error = (r_err != 2'd0);
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // datapath: factoring, write payloads, timeout, results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rate  <= '0;
      r_rem   <= '0;
      r_hb    <= '0;
      r_wcnt  <= '0;
      r_err   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_hb_en <= '0;
      r_cic   <= 8'd1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.cfg_valid) begin
            r_rate <= bus.cfg_rate;
            r_rem  <= bus.cfg_rate;
            r_hb   <= '0;
            r_err  <= '0;
          end
        end
        S_FACTOR: begin
          if (w_halve) begin
            r_hb  <= r_hb + 8'd1;
            r_rem <= r_rem >> 1;
          end
        end
        S_CHECK: begin
          if (w_rem_zero) r_err <= 2'd1;
          else if (w_rem_big) r_err <= 2'd2;
          else begin
            r_addr <= SR_M_ADDR;
            r_data <= {16'h0, r_rate};
          end
        end
        S_WR_M: r_wcnt <= '0;
        S_WAIT_M: begin
          if (w_ack) begin
            r_addr <= SR_INTERP_ADDR;
            r_data <= {16'h0, r_hb, r_rem[7:0]};
          end else if (w_tmo) r_err <= 2'd3;
          else r_wcnt <= r_wcnt + 16'd1;
        end
        S_WR_I: r_wcnt <= '0;
        S_WAIT_I: begin
          if (!w_ack) begin
            if (w_tmo) r_err <= 2'd3;
            else       r_wcnt <= r_wcnt + 16'd1;
          end
        end
        S_FINISH: begin
          if (r_err == 2'd0) begin
            r_hb_en <= r_hb;
            r_cic   <= r_rem[7:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cfg_ready           = w_ready;
  assign bus.m_ctrlport_req_wr   = w_wr;
  assign bus.m_ctrlport_req_addr = r_addr;
  assign bus.m_ctrlport_req_data = r_data;
  assign busy       = (r_state != S_IDLE);
  assign done       = w_done;
  assign error      = w_error;
  assign err_code   = r_err;
  assign hb_enables = r_hb_en;
  assign cic_rate   = r_cic;

endmodule

// File: tb/tb_duc_interp_ctrl.sv
// Testbench for duc_interp_ctrl: directed cases plus random
// rates and ack delays against a rate-factoring model.
module tb_duc_interp_ctrl;
  localparam int          NHB  = 3;
  localparam int          CMAX = 128;
  localparam logic [19:0] AM   = 20'h0;
  localparam logic [19:0] AI   = 20'h8;
  localparam int          TO   = 10;

  logic       clk = 0;
  logic       rst_n;
  logic       busy, done, error;
  logic [1:0] err_code;
  logic [7:0] hb_enables, cic_rate;
  int n_cmp = 0;
  int n_err = 0;
  int last_hb = 0;
  int last_cic = 1;

  duc_interp_ctrl_if bus();

  duc_interp_ctrl #(
    .NUM_HB(NHB), .CIC_MAX_INTERP(CMAX),
    .SR_M_ADDR(AM), .SR_INTERP_ADDR(AI), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .busy(busy), .done(done), .error(error),
    .err_code(err_code), .hb_enables(hb_enables),
    .cic_rate(cic_rate)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // strip factors of two (up to NHB of them), then range-check
  task automatic model(input int rate, output int hb,
                       output int rem, output int err);
    hb  = 0;
    rem = rate;
    while (rem != 0 && rem % 2 == 0 && hb < NHB) begin
      rem = rem / 2;
      hb  = hb + 1;
    end
    if (rem == 0)        err = 1;
    else if (rem > CMAX) err = 2;
    else                 err = 0;
  endtask

  // dm/di: cycles after each strobe at which ack pulses
  task automatic run_txn(input int rate, input int dm,
                         input int di, input bit ack_wrm);
    int hb, rem, err, eerr, efin, enwr, fm, si;
    int c, s_m, s_i, nwr;
    bit fin;
    model(rate, hb, rem, err);
    fm = hb + 2;
    si = -1;
    if (err != 0) begin
      eerr = err; efin = fm; enwr = 0;
    end else if (dm < 1 || dm > TO) begin
      eerr = 3; efin = fm + 1 + TO; enwr = 1;
    end else begin
      si   = fm + dm + 1;
      enwr = 2;
      if (di < 1 || di > TO) begin
        eerr = 3; efin = si + 1 + TO;
      end else begin
        eerr = 0; efin = si + di + 1;
      end
    end
    @(negedge clk);
    chk("ready_idle", bus.cfg_ready, 1);
    bus.cfg_valid = 1;
    bus.cfg_rate  = 16'(rate);
    @(negedge clk);
    bus.cfg_valid = 0;
    chk("busy_acc", busy, 1);
    c = 0; s_m = -1; s_i = -1; nwr = 0; fin = 0;
    while (!fin && c < 400) begin
      bus.m_ctrlport_resp_ack = 0;
      if (s_m >= 0 && s_i < 0 && c - s_m == dm)
        bus.m_ctrlport_resp_ack = 1;
      if (s_i >= 0 && c - s_i == di)
        bus.m_ctrlport_resp_ack = 1;
      if (bus.m_ctrlport_req_wr) begin
        if (nwr == 0) begin
          s_m = c;
          chk("m_addr", bus.m_ctrlport_req_addr, AM);
          chk("m_data", bus.m_ctrlport_req_data, 32'(rate));
          chk("m_cycle", c, fm);
          if (ack_wrm) bus.m_ctrlport_resp_ack = 1;
        end else if (nwr == 1) begin
          s_i = c;
          chk("i_addr", bus.m_ctrlport_req_addr, AI);
          chk("i_data", bus.m_ctrlport_req_data,
              32'(hb * 256 + rem % 256));
          chk("i_cycle", c, si);
        end
        nwr++;
      end
      if (done || error) begin
        fin = 1;
        chk("done", done, eerr == 0);
        chk("error", error, eerr != 0);
        chk("err_code", err_code, eerr);
        chk("fin_cycle", c, efin);
      end
      @(negedge clk);
      c++;
    end
    bus.m_ctrlport_resp_ack = 0;
    chk("finished", fin, 1);
    chk("n_writes", nwr, enwr);
    if (eerr == 0) begin
      last_hb  = hb;
      last_cic = rem % 256;
    end
    chk("busy_end", busy, 0);
    chk("hb_en", hb_enables, last_hb);
    chk("cic", cic_rate, last_cic);
    chk("err_hold", err_code, eerr);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, bus.cfg_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wr"}, bus.m_ctrlport_req_wr, 0);
    chk({tag, "_addr"}, bus.m_ctrlport_req_addr, 0);
    chk({tag, "_data"}, bus.m_ctrlport_req_data, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_ecode"}, err_code, 0);
    chk({tag, "_hb"}, hb_enables, 0);
    chk({tag, "_cic"}, cic_rate, 1);
  endtask

  initial begin
    int k, nw, r, dm, di;
    bit ackd, seen;
    rst_n = 0;
    bus.cfg_valid = 0;
    bus.cfg_rate = 0;
    bus.m_ctrlport_resp_ack = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1;

    run_txn(40, 2, 2, 0);
    run_txn(13, 1, 1, 0);
    run_txn(0, 1, 1, 0);
    run_txn(2048, 1, 1, 0);
    run_txn(40, 11, 1, 0);
    run_txn(40, 3, 1, 1);
    run_txn(12, 1, 11, 0);
    run_txn(40, 10, 10, 0);

    // cfg_valid held through FINISH
    @(negedge clk);
    bus.cfg_valid = 1;
    bus.cfg_rate = 0;
    k = 0; seen = 0;
    while (!seen && k < 20) begin
      @(negedge clk); k++;
      seen = error;
    end
    chk("hold_err1", seen, 1);
    @(negedge clk);
    chk("hold_idle", busy, 0);
    chk("hold_rdy", bus.cfg_ready, 1);
    @(negedge clk);
    chk("hold_acc", busy, 1);
    bus.cfg_valid = 0;
    k = 0; seen = 0;
    while (!seen && k < 20) begin
      @(negedge clk); k++;
      seen = error;
    end
    chk("hold_err2", seen, 1);
    chk("hold_code", err_code, 1);
    @(negedge clk);

    // reset during WAIT_I
    bus.cfg_valid = 1;
    bus.cfg_rate = 40;
    @(negedge clk);
    bus.cfg_valid = 0;
    k = 0; nw = 0; ackd = 0;
    while (nw < 2 && k < 100) begin
      @(negedge clk); k++;
      bus.m_ctrlport_resp_ack = 0;
      if (bus.m_ctrlport_req_wr) nw++;
      else if (nw == 1 && !ackd) begin
        bus.m_ctrlport_resp_ack = 1;
        ackd = 1;
      end
    end
    chk("rst_nw", nw, 2);
    repeat (2) @(negedge clk);
    chk("rst_inwait", busy, 1);
    rst_n = 0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1;
    bus.m_ctrlport_resp_ack = 1;
    @(negedge clk);
    bus.m_ctrlport_resp_ack = 0;
    for (int i = 0; i < 3; i++) begin
      chk("late_busy", busy, 0);
      chk("late_wr", bus.m_ctrlport_req_wr, 0);
      chk("late_pulse", done | error, 0);
      @(negedge clk);
    end
    last_hb = 0;
    last_cic = 1;
    run_txn(4, 2, 2, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       r = 0;
        1:       r = $urandom_range(0, 65535);
        default: r = $urandom_range(1, 255)
                     << $urandom_range(0, 4);
      endcase
      dm = $urandom_range(1, TO + 1);
      di = $urandom_range(1, TO + 1);
      run_txn(r, dm, di, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
